mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Arbitrates one single-ported unified memory between the pipelined core's instruction-fetch (IF) port and its data (MEM-stage) port.
- Allows one outstanding transaction at a time. Data has priority, and an anti-starvation counter protects fetch.
- A per-transaction watchdog returns an error response when memory never acknowledges, so the core cannot hang with a stuck PC.
- Sits between the core's IF/MEM stages and the memory model/controller.

Parameters:
- XLEN, 32, address/data width.
- STARVE_LIMIT, 4, consecutive IF-losing arbitrations before IF is forced to win (1..15).
- TIMEOUT_CYCLES, 1024, BUSY cycles without mem_ack before an error response (>=2).

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request; held until if_ready
- if_addr  in  XLEN  fetch address
- if_ready  out  1  fetch request accepted this cycle
- if_rvalid  out  1  fetch response valid (1-cycle pulse)
- if_rdata  out  XLEN  fetch read data
- if_err  out  1  fetch response is a timeout error
- d_req  in  1  data request; held until d_ready
- d_we  in  1  1 = write
- d_addr  in  XLEN  data address
- d_wdata  in  XLEN  write data
- d_wstrb  in  XLEN/8  byte strobes
- d_ready  out  1  data request accepted this cycle
- d_rvalid  out  1  data response valid (1-cycle pulse, for reads and writes)
- d_rdata  out  XLEN  data read data
- d_err  out  1  data response is a timeout error
- mem_req  out  1  memory request; held until mem_ack
- mem_we  out  1  write enable
- mem_addr  out  XLEN  address
- mem_wdata  out  XLEN  write data
- mem_wstrb  out  XLEN/8  strobes (0 for reads)
- mem_ack  in  1  completion; mem_rdata valid this cycle
- mem_rdata  in  XLEN  read data

Behaviour:
- FSM states: IDLE, BUSY_I, BUSY_D. Reset enters IDLE.
- Reset values: all registered outputs, counters, latched request fields, rdata and err are 0.
- IDLE arbitration is combinational; ready is asserted in the same cycle the request is seen:
  - If d_req and not (if_req and starve_cnt==STARVE_LIMIT): d_ready=1; latch D fields; go to BUSY_D.
  - Else if if_req: if_ready=1; latch if_addr with we=0, wstrb=0; go to BUSY_I.
  - At most one ready is high per cycle. Neither ready is high outside IDLE.
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) on each D grant while if_req=1.
  - Clears on any IF grant.
- BUSY_x:
  - mem_req=1 and mem_* driven from latched registers. These are stable for the whole transaction.
  - mem_ack sampled at an edge: next state is IDLE; x_rvalid=1 for one cycle; x_rdata=mem_rdata; x_err=0.
  - Minimum request-to-response latency is 2 cycles: accept at T, mem_req at T+1, ack at T+1, rvalid at T+2.
- A new grant may occur in the same cycle a response pulses, because the FSM is already in IDLE.
- Watchdog:
  - Counts BUSY cycles.
  - When the count reaches TIMEOUT_CYCLES without mem_ack: go to IDLE, x_rvalid=1, x_err=1, x_rdata=0.
  - mem_req drops the next cycle. A late mem_ack while IDLE is ignored.
  - Counter clears on entry to BUSY.
- mem_ack is ignored in IDLE.
- rdata holds its last value between pulses. err is valid only with rvalid.
- Reset asserted mid-transaction: immediately IDLE, mem_req=0, no response is ever produced for the dropped transaction, starve_cnt=0.
- Requests deasserted before ready are simply not served, with no side effects.

Decomposition:
- Package mem_arb_pkg holds:
  - the state enum (IDLE, BUSY_I, BUSY_D);
  - a port-select enum (PORT_I, PORT_D);
  - the default XLEN, STARVE_LIMIT and TIMEOUT_CYCLES constants.
- One natural sub-module, mem_txn_watchdog:
  - loadable up-counter with clear and enable inputs and an expire output;
  - instantiated once.
- All remaining logic stays in mem_port_arbiter.

Test Plan:
- IF only, addr 0x100, mem_ack on first BUSY cycle with rdata 0x00000013 -> if_ready at T, mem_req/mem_addr=0x100 at T+1, if_rvalid=1 and if_rdata=0x00000013 at T+2, d_* silent.
- D write and IF request in the same cycle (d_addr 0x2000, wdata 0xDEADBEEF, wstrb 0xF) -> D granted first, mem_we=1 and mem_wstrb=0xF; IF granted in the IDLE cycle after d_rvalid.
- d_req held continuously with if_req high, STARVE_LIMIT=4 -> exactly 4 D grants, then 1 IF grant, then D resumes; starve_cnt cleared.
- Read with no mem_ack, TIMEOUT_CYCLES=8 -> d_rvalid=1 and d_err=1 and d_rdata=0 after 8 BUSY cycles; FSM back in IDLE; a later mem_ack is ignored.
- reset pulsed during BUSY_I with memory stalled -> mem_req low immediately, no if_rvalid ever, next if_req accepted normally after reset release.
- Write accepted with mem_ack 3 cycles later -> mem_addr/wdata/wstrb constant across all BUSY cycles even if d_* inputs change after d_ready.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the IF/MEM unified-memory arbiter.
// Imported by the arbiter top and its transaction watchdog.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      BUSY_I,
      BUSY_D
   } state_t;

   typedef enum logic {
      PORT_I,
      PORT_D
   } port_sel_t;

   localparam int XLEN_DEF           = 32;
   localparam int STARVE_LIMIT_DEF   = 4;
   localparam int TIMEOUT_CYCLES_DEF = 1024;

endpackage

// File: rtl/mem_txn_watchdog.sv
// Per-transaction timeout counter: cleared while idle, counts busy cycles,
// flags expiry on the LIMIT-th counted cycle.
module mem_txn_watchdog import mem_arb_pkg::*; #(
   parameter int LIMIT = TIMEOUT_CYCLES_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic en,
   output logic expire
);

   localparam int CW = $clog2(LIMIT);

   logic [CW-1:0] cnt;

   assign expire = en && (cnt == CW'(LIMIT - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (en && !expire) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter of the unified memory between fetch and data
// ports: data first, fetch protected from starvation, watchdog on each txn.
module mem_port_arbiter import mem_arb_pkg::*; #(
   parameter int XLEN           = XLEN_DEF,
   parameter int STARVE_LIMIT   = STARVE_LIMIT_DEF,
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [XLEN-1:0]   if_addr,
   output logic              if_ready,
   output logic              if_rvalid,
   output logic [XLEN-1:0]   if_rdata,
   output logic              if_err,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [XLEN-1:0]   d_addr,
   input  logic [XLEN-1:0]   d_wdata,
   input  logic [XLEN/8-1:0] d_wstrb,
   output logic              d_ready,
   output logic              d_rvalid,
   output logic [XLEN-1:0]   d_rdata,
   output logic              d_err,
   output logic              mem_req,
   output logic              mem_we,
   output logic [XLEN-1:0]   mem_addr,
   output logic [XLEN-1:0]   mem_wdata,
   output logic [XLEN/8-1:0] mem_wstrb,
   input  logic              mem_ack,
   input  logic [XLEN-1:0]   mem_rdata
);

   state_t            state, next_state;
   port_sel_t         owner;
   logic              busy, done, expire;
   logic              grant_i, grant_d, starve_hit;
   logic [3:0]        starve_cnt;
   logic              lat_we;
   logic [XLEN-1:0]   lat_addr, lat_wdata;
   logic [XLEN/8-1:0] lat_wstrb;

   assign busy       = (state != IDLE);
   assign done       = busy && (mem_ack || expire);
   assign owner      = (state == BUSY_D) ? PORT_D : PORT_I;
   assign starve_hit = if_req && (starve_cnt == 4'(STARVE_LIMIT));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      grant_i    = 1'b0;
      grant_d    = 1'b0;
      case (state)
         IDLE: begin
            if (d_req && !starve_hit) begin
               grant_d    = 1'b1;
               next_state = BUSY_D;
            end else if (if_req) begin
               grant_i    = 1'b1;
               next_state = BUSY_I;
            end
         end
         BUSY_I, BUSY_D: begin
            if (mem_ack || expire) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   assign if_ready = grant_i;
   assign d_ready  = grant_d;

   // Request fields are frozen at grant so the core may move on immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lat_we    <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         lat_wstrb <= '0;
      end else if (grant_d) begin
         lat_we    <= d_we;
         lat_addr  <= d_addr;
         lat_wdata <= d_wdata;
         lat_wstrb <= d_we ? d_wstrb : '0;
      end else if (grant_i) begin
         lat_we    <= 1'b0;
         lat_addr  <= if_addr;
         lat_wdata <= '0;
         lat_wstrb <= '0;
      end
   end

   assign mem_req   = busy;
   assign mem_we    = lat_we;
   assign mem_addr  = lat_addr;
   assign mem_wdata = lat_wdata;
   assign mem_wstrb = lat_wstrb;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         starve_cnt <= '0;
      end else if (grant_i) begin
         starve_cnt <= '0;
      end else if (grant_d && if_req && !starve_hit) begin
         starve_cnt <= starve_cnt + 1'b1;
      end
   end

   // An ack in the expiry cycle still counts as a normal completion.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         if_rvalid <= 1'b0;
         if_rdata  <= '0;
         if_err    <= 1'b0;
         d_rvalid  <= 1'b0;
         d_rdata   <= '0;
         d_err     <= 1'b0;
      end else begin
         if_rvalid <= done && (owner == PORT_I);
         if_err    <= done && (owner == PORT_I) && !mem_ack;
         d_rvalid  <= done && (owner == PORT_D);
         d_err     <= done && (owner == PORT_D) && !mem_ack;
         if (done && owner == PORT_I) if_rdata <= mem_ack ? mem_rdata : '0;
         if (done && owner == PORT_D) d_rdata  <= mem_ack ? mem_rdata : '0;
      end
   end

   mem_txn_watchdog #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk    (clk),
      .reset  (reset),
      .clear  (!busy),
      .en     (busy),
      .expire (expire)
   );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch/data grants, priority,
// starvation relief, watchdog timeout, reset abort and request stability.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_ready, if_rvalid, if_err;
   logic [31:0] if_rdata;
   logic        d_req, d_we;
   logic [31:0] d_addr, d_wdata;
   logic [3:0]  d_wstrb;
   logic        d_ready, d_rvalid, d_err;
   logic [31:0] d_rdata;
   logic        mem_req, mem_we, mem_ack;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_wstrb;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(
      .XLEN           (32),
      .STARVE_LIMIT   (4),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_ready  (if_ready),
      .if_rvalid (if_rvalid),
      .if_rdata  (if_rdata),
      .if_err    (if_err),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_wstrb   (d_wstrb),
      .d_ready   (d_ready),
      .d_rvalid  (d_rvalid),
      .d_rdata   (d_rdata),
      .d_err     (d_err),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_wstrb (mem_wstrb),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      string seq;
      int    n;
      reset     = 1'b1;
      if_req    = 1'b0;
      if_addr   = '0;
      d_req     = 1'b0;
      d_we      = 1'b0;
      d_addr    = '0;
      d_wdata   = '0;
      d_wstrb   = '0;
      mem_ack   = 1'b0;
      mem_rdata = '0;
      tick();
      tick();
      #1;
      chk("rst_mem_req", 32'(mem_req), 0);
      chk("rst_if_rvalid", 32'(if_rvalid), 0);
      chk("rst_d_rvalid", 32'(d_rvalid), 0);
      chk("rst_if_rdata", if_rdata, 0);
      chk("rst_mem_addr", mem_addr, 0);
      tick();
      reset = 1'b0;

      // IF-only read, ack on first busy cycle
      tick();
      if_req  = 1'b1;
      if_addr = 32'h100;
      #1;
      chk("t1_if_ready", 32'(if_ready), 1);
      chk("t1_d_ready", 32'(d_ready), 0);
      chk("t1_mem_req_T", 32'(mem_req), 0);
      tick();
      if_req    = 1'b0;
      mem_ack   = 1'b1;
      mem_rdata = 32'h00000013;
      #1;
      chk("t1_mem_req", 32'(mem_req), 1);
      chk("t1_mem_addr", mem_addr, 32'h100);
      chk("t1_mem_we", 32'(mem_we), 0);
      chk("t1_if_rvalid_T1", 32'(if_rvalid), 0);
      tick();
      mem_ack = 1'b0;
      #1;
      chk("t1_if_rvalid", 32'(if_rvalid), 1);
      chk("t1_if_rdata", if_rdata, 32'h13);
      chk("t1_if_err", 32'(if_err), 0);
      chk("t1_d_rvalid", 32'(d_rvalid), 0);
      chk("t1_mem_req_idle", 32'(mem_req), 0);
      tick();
      #1;
      chk("t1_if_rvalid_pulse", 32'(if_rvalid), 0);
      chk("t1_if_rdata_hold", if_rdata, 32'h13);

      // D write and IF read arrive together: D first
      tick();
      d_req   = 1'b1;
      d_we    = 1'b1;
      d_addr  = 32'h2000;
      d_wdata = 32'hDEADBEEF;
      d_wstrb = 4'hF;
      if_req  = 1'b1;
      if_addr = 32'h104;
      #1;
      chk("t2_d_ready", 32'(d_ready), 1);
      chk("t2_if_ready", 32'(if_ready), 0);
      tick();
      d_req     = 1'b0;
      mem_ack   = 1'b1;
      mem_rdata = 32'h0;
      #1;
      chk("t2_mem_we", 32'(mem_we), 1);
      chk("t2_mem_wstrb", 32'(mem_wstrb), 32'hF);
      chk("t2_mem_addr", mem_addr, 32'h2000);
      chk("t2_mem_wdata", mem_wdata, 32'hDEADBEEF);
      chk("t2_if_ready_busy", 32'(if_ready), 0);
      tick();
      mem_ack = 1'b0;
      #1;
      chk("t2_d_rvalid", 32'(d_rvalid), 1);
      chk("t2_d_err", 32'(d_err), 0);
      chk("t2_if_ready", 32'(if_ready), 1);
      tick();
      if_req    = 1'b0;
      mem_ack   = 1'b1;
      mem_rdata = 32'hAAAA5555;
      #1;
      chk("t2_mem_addr_if", mem_addr, 32'h104);
      chk("t2_mem_we_if", 32'(mem_we), 0);
      tick();
      mem_ack = 1'b0;
      #1;
      chk("t2_if_rvalid", 32'(if_rvalid), 1);
      chk("t2_if_rdata", if_rdata, 32'hAAAA5555);

      // starvation relief: both held, memory acks every busy cycle
      tick();
      d_req     = 1'b1;
      d_we      = 1'b0;
      d_addr    = 32'h3000;
      d_wstrb   = 4'hF;
      if_req    = 1'b1;
      if_addr   = 32'h200;
      mem_ack   = 1'b1;
      mem_rdata = 32'h5A5A0001;
      seq = "";
      n   = 0;
      for (int c = 0; c < 20 && n < 6; c++) begin
         #1;
         chk("t3_one_ready", 32'(if_ready && d_ready), 0);
         if (d_ready) begin
            seq = {seq, "D"};
            n++;
         end else if (if_ready) begin
            seq = {seq, "I"};
            n++;
         end
         if (mem_req && !mem_we) chk("t3_rd_wstrb", 32'(mem_wstrb), 0);
         if (n < 6) tick();
      end
      if (seq != "DDDDID")
         begin
            errors++;
            $display("FAIL t3_grant_seq: got %s expected DDDDID", seq);
         end
      checks++;
      tick();
      d_req  = 1'b0;
      if_req = 1'b0;
      tick();
      mem_ack = 1'b0;
      #1;
      chk("t3_d_rdata", d_rdata, 32'h5A5A0001);

      // watchdog: data read never acknowledged
      tick();
      d_req  = 1'b1;
      d_we   = 1'b0;
      d_addr = 32'h3004;
      #1;
      chk("t4_d_ready", 32'(d_ready), 1);
      tick();
      d_req = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         #1;
         chk($sformatf("t4_busy%0d_req", i), 32'(mem_req), 1);
         chk($sformatf("t4_busy%0d_rv", i), 32'(d_rvalid), 0);
         tick();
      end
      mem_ack   = 1'b1;
      mem_rdata = 32'h11112222;
      #1;
      chk("t4_d_rvalid", 32'(d_rvalid), 1);
      chk("t4_d_err", 32'(d_err), 1);
      chk("t4_d_rdata", d_rdata, 0);
      chk("t4_mem_req_drop", 32'(mem_req), 0);
      tick();
      mem_ack = 1'b0;
      #1;
      chk("t4_late_ack_d", 32'(d_rvalid), 0);
      chk("t4_late_ack_i", 32'(if_rvalid), 0);
      chk("t4_late_ack_req", 32'(mem_req), 0);
      chk("t4_d_rdata_hold", d_rdata, 0);

      // reset during a stalled fetch
      tick();
      if_req  = 1'b1;
      if_addr = 32'h400;
      #1;
      chk("t5_if_ready", 32'(if_ready), 1);
      tick();
      if_req = 1'b0;
      #1;
      chk("t5_mem_req", 32'(mem_req), 1);
      reset = 1'b1;
      #1;
      chk("t5_rst_mem_req", 32'(mem_req), 0);
      tick();
      reset     = 1'b0;
      mem_ack   = 1'b1;
      mem_rdata = 32'hBADBAD00;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("t5_no_rvalid%0d", i), 32'(if_rvalid), 0);
      end
      mem_ack = 1'b0;
      if_req  = 1'b1;
      if_addr = 32'h500;
      #1;
      chk("t5_if_ready2", 32'(if_ready), 1);
      tick();
      if_req    = 1'b0;
      mem_ack   = 1'b1;
      mem_rdata = 32'h77;
      #1;
      chk("t5_mem_addr2", mem_addr, 32'h500);
      tick();
      mem_ack = 1'b0;
      #1;
      chk("t5_if_rvalid2", 32'(if_rvalid), 1);
      chk("t5_if_rdata2", if_rdata, 32'h77);

      // write held stable while inputs wander, ack on 3rd busy cycle
      tick();
      d_req   = 1'b1;
      d_we    = 1'b1;
      d_addr  = 32'h2004;
      d_wdata = 32'h12345678;
      d_wstrb = 4'h3;
      #1;
      chk("t6_d_ready", 32'(d_ready), 1);
      tick();
      d_req   = 1'b0;
      d_we    = 1'b0;
      d_addr  = 32'hFFFF;
      d_wdata = 32'h0;
      d_wstrb = 4'hC;
      for (int i = 1; i <= 3; i++) begin
         mem_ack = (i == 3);
         #1;
         chk($sformatf("t6_addr%0d", i), mem_addr, 32'h2004);
         chk($sformatf("t6_wdata%0d", i), mem_wdata, 32'h12345678);
         chk($sformatf("t6_wstrb%0d", i), 32'(mem_wstrb), 32'h3);
         chk($sformatf("t6_we%0d", i), 32'(mem_we), 1);
         chk($sformatf("t6_req%0d", i), 32'(mem_req), 1);
         tick();
      end
      mem_ack = 1'b0;
      #1;
      chk("t6_d_rvalid", 32'(d_rvalid), 1);
      chk("t6_d_err", 32'(d_err), 0);
      chk("t6_mem_req_idle", 32'(mem_req), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1);
   end

endmodule
